data_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache in the MEM stage of the pipelined MIPS core, between MEM-stage address/data logic and the main data memory.
- Block = one 32-bit word held as four bytes; byte 0 is the most significant byte (big-endian).
- Byte stores are merged by the MEM stage through read-modify-write on cache_data_out, so the cache only ever writes whole words.
- hit low means stall the pipeline.

---
 rtl/data_cache_pkg.sv | 22 ++
 rtl/data_cache_array.sv | 61 ++++++
 rtl/data_cache.sv | 151 +++++++++++++++
 tb/tb_data_cache.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types for the MEM-stage data cache, its requester and the memory model.
`timescale 1ns/1ps
package data_cache_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [7:0] byte_t;
  typedef byte_t word_bytes_t [4];

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} cache_state_e;

  // Big-endian: byte 0 lands in bits [31:24].
  function automatic logic [31:0] pack_word(input word_bytes_t b);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[31-8*i -: 8] = b[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage for the data cache: resettable valid/dirty bits, unreset tag and data arrays,
// one asynchronous read port and one synchronous write port.
`timescale 1ns/1ps
module data_cache_array #(
  parameter int unsigned INDEX_BITS = 11,
  parameter int unsigned TAG_W      = 19
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  wr_dirty_i
);

  localparam int unsigned Lines = 1 << INDEX_BITS;

  logic [Lines-1:0] valid_q, valid_d;
  logic [Lines-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_mem  [Lines];
  logic [31:0]      data_mem [Lines];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = wr_dirty_i;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are only meaningful once valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate one-word-per-line data cache for the MEM stage.
// hit low stalls the pipeline while a dirty line is written back and/or a line is refilled.
`timescale 1ns/1ps
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 11,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cache_en,
  input  logic              cache_write_en,
  input  logic [ADDR_W-1:0] cache_addr,
  input  word_bytes_t       cache_data_in,
  output word_bytes_t       cache_data_out,
  output logic              hit,
  output logic [ADDR_W-1:0] mem_addr,
  output word_bytes_t       mem_data_in,
  output logic              mem_write_en,
  input  word_bytes_t       mem_data_out
);

  localparam int unsigned TagW = ADDR_W - 2 - INDEX_BITS;
  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY - 1);

  cache_state_e          state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TagW-1:0]       miss_tag_q, miss_tag_d;
  logic                  mem_we_q, mem_we_d;

  logic [INDEX_BITS-1:0] req_idx, rd_idx, wr_idx;
  logic [TagW-1:0]       req_tag, rd_tag, wr_tag;
  logic                  rd_valid, rd_dirty, tag_match;
  logic [31:0]           rd_data, wr_data;
  logic                  arr_we, wr_dirty;
  logic [1:0]            unused_offset;

  assign unused_offset = cache_addr[1:0];
  assign req_idx       = cache_addr[INDEX_BITS+1:2];
  assign req_tag       = cache_addr[ADDR_W-1:INDEX_BITS+2];

  // Outside IDLE the array is addressed by the latched miss so an abandoned request still lands.
  assign rd_idx    = (state_q == IDLE) ? req_idx : miss_idx_q;
  assign tag_match = rd_valid && (rd_tag == req_tag);
  assign hit       = (state_q == IDLE) && (!cache_en || tag_match);

  data_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TagW)
  ) u_array (
    .clk        (clk),
    .rst_b      (rst_b),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (arr_we),
    .wr_idx_i   (wr_idx),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data),
    .wr_dirty_i (wr_dirty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    mem_we_d   = 1'b0;
    arr_we     = 1'b0;
    wr_idx     = req_idx;
    wr_tag     = req_tag;
    wr_data    = pack_word(cache_data_in);
    wr_dirty   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (cache_en) begin
          if (tag_match) begin
            arr_we = cache_write_en;
          end else begin
            miss_idx_d = req_idx;
            miss_tag_d = req_tag;
            cnt_d      = '0;
            if (rd_valid && rd_dirty) begin
              state_d  = WRITEBACK;
              mem_we_d = 1'b1;
            end else begin
              state_d = REFILL;
            end
          end
        end
      end
      WRITEBACK: begin
        state_d = REFILL;
        cnt_d   = '0;
      end
      REFILL: begin
        if (cnt_q == CntLast) begin
          arr_we   = 1'b1;
          wr_idx   = miss_idx_q;
          wr_tag   = miss_tag_q;
          wr_data  = pack_word(mem_data_out);
          wr_dirty = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign mem_write_en = mem_we_q;

  always_comb begin
    unique case (state_q)
      IDLE:      mem_addr = {cache_addr[ADDR_W-1:2], 2'b00};
      WRITEBACK: mem_addr = {rd_tag, miss_idx_q, 2'b00};
      default:   mem_addr = {miss_tag_q, miss_idx_q, 2'b00};
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cache_data_out[i] = rd_data[31-8*i -: 8];
      mem_data_in[i]    = rd_data[31-8*i -: 8];
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic against a
// line-level reference model and a flat memory model that records every write-back.
`timescale 1ns/1ps
module tb_data_cache;
  import data_cache_pkg::*;

  localparam int unsigned IB  = 11;
  localparam int unsigned LAT = 4;
  localparam int unsigned MemWords = 1 << 14;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cache_en = 1'b0;
  logic        cache_write_en = 1'b0;
  logic [31:0] cache_addr = '0;
  word_bytes_t cache_data_in;
  word_bytes_t cache_data_out;
  logic        hit;
  logic [31:0] mem_addr;
  word_bytes_t mem_data_in;
  logic        mem_write_en;
  word_bytes_t mem_data_out;

  int tests = 0;
  int fails = 0;

  // Memory seen by the DUT, and what memory is expected to hold.
  logic [31:0] mem     [MemWords];
  logic [31:0] ref_mem [MemWords];
  logic [31:0] wb_addr_q [$];
  logic [31:0] wb_data_q [$];

  // Reference cache contents, one entry per line.
  bit          rv   [2048];
  bit          rdty [2048];
  logic [18:0] rtag [2048];
  logic [31:0] rdat [2048];

  always #5 clk = ~clk;

  data_cache #(
    .INDEX_BITS  (IB),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .cache_en       (cache_en),
    .cache_write_en (cache_write_en),
    .cache_addr     (cache_addr),
    .cache_data_in  (cache_data_in),
    .cache_data_out (cache_data_out),
    .hit            (hit),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_write_en   (mem_write_en),
    .mem_data_out   (mem_data_out)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_data_out[i] = mem[mem_addr[15:2]][31-8*i -: 8];
    end
  end

  always @(posedge clk) begin
    if (rst_b && mem_write_en) begin
      mem[mem_addr[15:2]] <= pack_word(mem_data_in);
      wb_addr_q.push_back(mem_addr);
      wb_data_q.push_back(pack_word(mem_data_in));
    end
  end

  task automatic set_wdata(input logic [31:0] w);
    for (int i = 0; i < 4; i++) cache_data_in[i] = w[31-8*i -: 8];
  endtask

  // One request: drives it, waits for hit, checks latency, data and write-back traffic,
  // then advances the reference model. drop_at >= 0 releases cache_en mid-miss (loads only).
  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int drop_at);
    logic [10:0] idx;
    logic [18:0] tg;
    bit          exp_hit, exp_dirty;
    int          exp_lat, cyc, wb_before;
    logic [31:0] exp_wb_addr, exp_wb_data, got;
    idx       = addr[12:2];
    tg        = addr[31:13];
    exp_hit   = rv[idx] && (rtag[idx] == tg);
    exp_dirty = !exp_hit && rv[idx] && rdty[idx];
    exp_lat   = exp_hit ? 0 : (exp_dirty ? LAT + 2 : LAT + 1);
    exp_wb_addr = {rtag[idx], idx, 2'b00};
    exp_wb_data = rdat[idx];
    wb_before = wb_addr_q.size();

    @(negedge clk);
    cache_en       = 1'b1;
    cache_write_en = we;
    cache_addr     = addr;
    set_wdata(wdata);
    #1;
    cyc = 0;
    while (hit !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == drop_at) begin
        cache_en = 1'b0;
        #1;
      end
    end
    tests++;
    if (cyc != exp_lat) begin
      fails++;
      $display("FAIL latency addr=%08h: hit after %0d cycles, required %0d", addr, cyc, exp_lat);
    end

    if (!exp_hit) begin
      if (exp_dirty) ref_mem[exp_wb_addr[15:2]] = exp_wb_data;
      rv[idx]   = 1'b1;
      rdty[idx] = 1'b0;
      rtag[idx] = tg;
      rdat[idx] = ref_mem[addr[15:2]];
    end
    got = pack_word(cache_data_out);
    tests++;
    if (got !== rdat[idx]) begin
      fails++;
      $display("FAIL read_data addr=%08h: got %08h, required %08h", addr, got, rdat[idx]);
    end

    tests++;
    if (exp_dirty) begin
      if (wb_addr_q.size() != wb_before + 1) begin
        fails++;
        $display("FAIL writeback_count addr=%08h: got %0d writes, required 1", addr,
                 wb_addr_q.size() - wb_before);
      end else if (wb_addr_q[wb_before] !== exp_wb_addr || wb_data_q[wb_before] !== exp_wb_data)
      begin
        fails++;
        $display("FAIL writeback addr=%08h: got %08h<-%08h, required %08h<-%08h", addr,
                 wb_addr_q[wb_before], wb_data_q[wb_before], exp_wb_addr, exp_wb_data);
      end
    end else if (wb_addr_q.size() != wb_before) begin
      fails++;
      $display("FAIL no_writeback addr=%08h: got %0d writes, required 0", addr,
               wb_addr_q.size() - wb_before);
    end

    if (we && drop_at < 0) begin
      rdat[idx] = wdata;
      rdty[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    cache_en       = 1'b0;
    cache_write_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_b    = 1'b0;
    cache_en = 1'b0;
    #12;
    tests++;
    if (hit !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_hit: got %b, required 1", hit);
    end
    tests++;
    if (mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_mem_we: got %b, required 0", mem_write_en);
    end
    cache_en   = 1'b1;
    cache_addr = 32'h0000_0013;
    #1;
    tests++;
    if (hit !== 1'b0) begin
      fails++;
      $display("FAIL reset_invalid: hit got %b, required 0", hit);
    end
    tests++;
    if (mem_addr !== 32'h0000_0010) begin
      fails++;
      $display("FAIL idle_mem_addr: got %08h, required 00000010", mem_addr);
    end
    cache_en = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_directed();
    access(32'h0000_0010, 1'b0, 32'h0, -1);
    access(32'h0000_0010, 1'b0, 32'h0, -1);
    access(32'h0000_0010, 1'b1, 32'h1122_3344, -1);
    access(32'h0000_0010, 1'b0, 32'h0, -1);
    tests++;
    if (mem[4] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL write_back_policy: memory got %08h, required deadbeef", mem[4]);
    end
    access(32'h0000_2010, 1'b0, 32'h0, -1);
    tests++;
    if (mem[4] !== 32'h1122_3344) begin
      fails++;
      $display("FAIL evicted_word: memory got %08h, required 11223344", mem[4]);
    end
    access(32'h0000_0020, 1'b1, 32'hCAFE_F00D, -1);
    access(32'h0000_0020, 1'b0, 32'h0, -1);
    access(32'h0000_2020, 1'b0, 32'h0, -1);
  endtask

  task automatic test_ignored_write();
    @(negedge clk);
    cache_en       = 1'b0;
    cache_write_en = 1'b1;
    cache_addr     = 32'h0000_2010;
    set_wdata(32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    cache_write_en = 1'b0;
    access(32'h0000_2010, 1'b0, 32'h0, -1);
  endtask

  task automatic test_abandon();
    access(32'h0000_3040, 1'b1, 32'h5555_AAAA, -1);
    access(32'h0000_5040, 1'b0, 32'h0, 2);
    access(32'h0000_5040, 1'b0, 32'h0, -1);
  endtask

  task automatic test_random();
    logic [10:0] idx;
    logic [31:0] addr;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: idx = 11'd0;
        1: idx = 11'd1;
        2: idx = 11'd4;
        3: idx = 11'd2047;
        default: idx = 11'($urandom_range(0, 15));
      endcase
      addr = {17'd0, 2'($urandom_range(0, 3)), idx, 2'($urandom_range(0, 3))};
      access(addr, 1'($urandom_range(0, 1)), $urandom, -1);
    end
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    cache_en       = 1'b1;
    cache_write_en = 1'b0;
    cache_addr     = 32'h0000_6010;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    #1;
    tests++;
    if (hit !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_refill_invalid: hit got %b, required 0", hit);
    end
    tests++;
    if (mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_refill_we: got %b, required 0", mem_write_en);
    end
    cache_en = 1'b0;
    #1;
    tests++;
    if (hit !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_refill_idle: hit got %b, required 1", hit);
    end
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      rv[i]   = 1'b0;
      rdty[i] = 1'b0;
    end
    access(32'h0000_0010, 1'b0, 32'h0, -1);
  endtask

  initial begin
    for (int i = 0; i < int'(MemWords); i++) begin
      mem[i]     = (i * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 2048; i++) begin
      rv[i]   = 1'b0;
      rdty[i] = 1'b0;
      rtag[i] = '0;
      rdat[i] = '0;
    end
    set_wdata(32'h0);

    test_reset();
    test_directed();
    test_ignored_write();
    test_abandon();
    test_random();
    test_reset_mid_refill();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
